ook_frame_encoder: RTL



---
 rtl/hunter_pkg.sv | 30 +++
 rtl/chip_timer.sv | 29 ++
 rtl/ook_frame_encoder.sv | 115 +++++++++++
 3 files changed

// File: rtl/hunter_pkg.sv
// hunter_pkg: command codes, frame state encoding and the cmd-to-code mapping
// shared by the fan-remote OOK encoders.
package hunter_pkg;

    localparam logic [7:0] CMD_SPEED0  = 8'h10;
    localparam logic [7:0] CMD_SPEED1  = 8'h21;
    localparam logic [7:0] CMD_SPEED2  = 8'h42;
    localparam logic [7:0] CMD_SPEED3  = 8'h84;
    localparam logic [7:0] CMD_LIGHT   = 8'h0F;
    localparam logic [7:0] CMD_RELEASE = 8'h00;

    typedef enum logic [2:0] {IDLE, SYNC_HI, SYNC_LO, BITS, TAIL} state_t;

    // cmd 5 and 6 are reserved and never produce a frame
    function automatic logic cmd_ok(input logic [2:0] cmd);
        return cmd != 3'd5 && cmd != 3'd6;
    endfunction

    function automatic logic [7:0] cmd_code(input logic [2:0] cmd);
        case (cmd)
            3'd0:    return CMD_SPEED0;
            3'd1:    return CMD_SPEED1;
            3'd2:    return CMD_SPEED2;
            3'd3:    return CMD_SPEED3;
            3'd4:    return CMD_LIGHT;
            default: return CMD_RELEASE;
        endcase
    endfunction

endpackage

// File: rtl/chip_timer.sv
// chip_timer: chip-period down-counter; tc marks the last cycle of each chip
// and the counter reloads itself so chips run back to back while enabled.
module chip_timer #(
    parameter int CHIP_CYCLES = 1200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int W = CHIP_CYCLES > 1 ? $clog2(CHIP_CYCLES) : 1;
    localparam logic [W-1:0] TOP = W'(CHIP_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else if (load || tc)
            count <= TOP;
        else if (en)
            count <= count - 1'b1;
    end

    assign tc = en && count == '0;

endmodule

// File: rtl/ook_frame_encoder.sv
// ook_frame_encoder: turns one start request plus a fan command into a single
// OOK frame (sync mark, address, command code, silent tail) with PWM data bits.
module ook_frame_encoder
    import hunter_pkg::*;
#(
    parameter int CHIP_CYCLES     = 1200,
    parameter int SYNC_HIGH_CHIPS = 4,
    parameter int SYNC_LOW_CHIPS  = 10,
    parameter int ADDR_BITS       = 24,
    parameter logic [ADDR_BITS-1:0] ADDRESS = 24'hA5C31E,
    parameter int TAIL_CHIPS      = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] cmd,
    input  logic       start_packet,
    output logic       ook,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int NB   = ADDR_BITS + 8;
    localparam int BW   = $clog2(NB);
    localparam int MX1  = SYNC_HIGH_CHIPS > SYNC_LOW_CHIPS ? SYNC_HIGH_CHIPS : SYNC_LOW_CHIPS;
    localparam int MXC  = MX1 > TAIL_CHIPS ? MX1 : TAIL_CHIPS;
    localparam int CW   = MXC > 1 ? $clog2(MXC) : 1;

    state_t          state, state_d;
    logic [CW-1:0]   chip_cnt, chip_cnt_d;
    logic [1:0]      chip_idx, chip_idx_d;
    logic [BW-1:0]   bit_cnt, bit_cnt_d;
    logic [NB-1:0]   shreg, shreg_d;
    logic            accept, ook_d, tc;

    chip_timer #(.CHIP_CYCLES(CHIP_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .en      (busy),
        .tc      (tc)
    );

    assign busy = state != IDLE;
    assign done = state == TAIL && tc && chip_cnt == '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            chip_cnt <= '0;
            chip_idx <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ook      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_d;
            chip_cnt <= chip_cnt_d;
            chip_idx <= chip_idx_d;
            bit_cnt  <= bit_cnt_d;
            shreg    <= shreg_d;
            ook      <= ook_d;
            overrun  <= start_packet && !accept;
        end
    end

    always_comb begin
        state_d    = state;
        chip_cnt_d = chip_cnt;
        chip_idx_d = chip_idx;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        accept     = start_packet && state == IDLE && cmd_ok(cmd);
        case (state)
            IDLE:
                if (accept) begin
                    state_d    = SYNC_HI;
                    chip_cnt_d = CW'(SYNC_HIGH_CHIPS - 1);
                    shreg_d    = {ADDRESS, cmd_code(cmd)};
                end
            SYNC_HI:
                if (tc) begin
                    state_d    = chip_cnt == '0 ? SYNC_LO : SYNC_HI;
                    chip_cnt_d = chip_cnt == '0 ? CW'(SYNC_LOW_CHIPS - 1) : chip_cnt - 1'b1;
                end
            SYNC_LO:
                if (tc) begin
                    state_d    = chip_cnt == '0 ? BITS : SYNC_LO;
                    chip_cnt_d = chip_cnt - 1'b1;
                    chip_idx_d = '0;
                    bit_cnt_d  = BW'(NB - 1);
                end
            BITS:
                if (tc && chip_idx == 2'd2) begin
                    state_d    = bit_cnt == '0 ? TAIL : BITS;
                    chip_cnt_d = CW'(TAIL_CHIPS - 1);
                    chip_idx_d = '0;
                    bit_cnt_d  = bit_cnt - 1'b1;
                    shreg_d    = shreg << 1;
                end else if (tc) begin
                    chip_idx_d = chip_idx + 1'b1;
                end
            TAIL:
                if (tc) begin
                    state_d    = chip_cnt == '0 ? IDLE : TAIL;
                    chip_cnt_d = chip_cnt - 1'b1;
                end
            default: state_d = IDLE;
        endcase
        // carrier for the coming cycle: chip 0 always on, chip 1 carries the bit
        ook_d = state_d == SYNC_HI ||
                (state_d == BITS && (chip_idx_d == 2'd0 || (chip_idx_d == 2'd1 && shreg_d[NB-1])));
    end

endmodule
